// File: rtl/cfg_txn_launcher.sv
// Config-bus slave that stages one transaction's arguments, launches it to the
// downstream engine on a valid/ready handshake and reports status and a
// completion count. Optional response timeout: define CFG_TXN_TIMEOUT_EN.
module cfg_txn_launcher #(
    parameter int CFG_ADDR_W     = 12,
    parameter int DATA_W         = 64,
    parameter int PADDR_W        = 40,
    parameter int OP_W           = 2,
    parameter int SIZE_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [CFG_ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0]     cfg_data,
    input  logic [2:0]            cfg_size,
    input  logic                  cfg_type,
    output logic [DATA_W-1:0]     cfg_read_data,
    output logic                  cfg_read_valid,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [PADDR_W-1:0]    req_addr,
    output logic [OP_W-1:0]       req_op,
    output logic [SIZE_W-1:0]     req_size,
    input  logic                  resp_valid,
    input  logic                  resp_err
);

    localparam logic [CFG_ADDR_W-1:0] A_TXN_ADDR = CFG_ADDR_W'('h00);
    localparam logic [CFG_ADDR_W-1:0] A_TXN_OP   = CFG_ADDR_W'('h04);
    localparam logic [CFG_ADDR_W-1:0] A_TXN_SIZE = CFG_ADDR_W'('h08);
    localparam logic [CFG_ADDR_W-1:0] A_CTRL     = CFG_ADDR_W'('h0C);
    localparam logic [CFG_ADDR_W-1:0] A_STATUS   = CFG_ADDR_W'('h10);
    localparam logic [CFG_ADDR_W-1:0] A_DONE_CNT = CFG_ADDR_W'('h14);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [PADDR_W-1:0] txn_addr;
    logic [OP_W-1:0]    txn_op;
    logic [SIZE_W-1:0]  txn_size;
    logic               done;
    logic               err;
    logic               err_timeout;
    logic [31:0]        done_cnt;

    logic               wr;
    logic               rd;
    logic               start_req;
    logic [2:0]         status_w1c;
    logic               launch;
    logic               zero_done;
    logic               complete;
    logic               reject;
    logic               timeout;
    logic [DATA_W-1:0]  rd_mux;

    // Access size is fixed at full-register; upper data bits have no home.
    logic unused_bits;
    assign unused_bits = ^{cfg_size, cfg_data};

    assign wr         = cfg_valid & cfg_type;
    assign rd         = cfg_valid & ~cfg_type;
    assign start_req  = wr && (cfg_addr == A_CTRL) && cfg_data[0];
    assign status_w1c = (wr && (cfg_addr == A_STATUS)) ? cfg_data[2:0] : 3'b000;
    assign req_valid  = (state == ISSUE);

`ifdef CFG_TXN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    // Counter is held at zero outside WAIT, so it starts from 0 on entry.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) wait_cnt <= '0;
        else                      wait_cnt <= wait_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no latches form.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        zero_done  = 1'b0;
        complete   = 1'b0;
        reject     = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    if (txn_size != '0) begin
                        launch     = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end
            ISSUE: begin
                reject = start_req;
                if (req_ready) state_next = WAIT;
            end
            WAIT: begin
                reject = start_req;
                if (resp_valid) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
`ifdef CFG_TXN_TIMEOUT_EN
                else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_addr <= '0;
            txn_op   <= '0;
            txn_size <= '0;
        end else if (wr) begin
            if (cfg_addr == A_TXN_ADDR) txn_addr <= cfg_data[PADDR_W-1:0];
            if (cfg_addr == A_TXN_OP)   txn_op   <= cfg_data[OP_W-1:0];
            if (cfg_addr == A_TXN_SIZE) txn_size <= cfg_data[SIZE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr <= '0;
            req_op   <= '0;
            req_size <= '0;
        end else if (launch) begin
            req_addr <= txn_addr;
            req_op   <= txn_op;
            req_size <= txn_size;
        end
    end

    // Hardware sets take priority over software W1C of the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            err      <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (launch)                              done <= 1'b0;
            else if (complete || timeout || zero_done) done <= 1'b1;
            else if (status_w1c[0])                  done <= 1'b0;

            if (launch)                                err <= 1'b0;
            else if (reject || zero_done || timeout)   err <= 1'b1;
            else if (complete)                         err <= resp_err;
            else if (status_w1c[1])                    err <= 1'b0;

            if (complete || timeout || zero_done) done_cnt <= done_cnt + 32'd1;
        end
    end

`ifdef CFG_TXN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst)                err_timeout <= 1'b0;
        else if (launch)        err_timeout <= 1'b0;
        else if (timeout)       err_timeout <= 1'b1;
        else if (status_w1c[2]) err_timeout <= 1'b0;
    end
`else
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            A_TXN_ADDR: rd_mux = DATA_W'(txn_addr);
            A_TXN_OP:   rd_mux = DATA_W'(txn_op);
            A_TXN_SIZE: rd_mux = DATA_W'(txn_size);
            A_CTRL:     rd_mux = DATA_W'(state != IDLE);
            A_STATUS:   rd_mux = DATA_W'({err_timeout, err, done});
            A_DONE_CNT: rd_mux = DATA_W'(done_cnt);
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_read_valid <= 1'b0;
            cfg_read_data  <= '0;
        end else begin
            cfg_read_valid <= rd;
            cfg_read_data  <= rd ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_cfg_txn_launcher.sv
// Directed bench for cfg_txn_launcher; timeout checks follow CFG_TXN_TIMEOUT_EN.
module tb_cfg_txn_launcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [11:0] cfg_addr;
    logic [63:0] cfg_data;
    logic [2:0]  cfg_size;
    logic        cfg_type;
    logic [63:0] cfg_read_data;
    logic        cfg_read_valid;
    logic        req_valid;
    logic        req_ready;
    logic [39:0] req_addr;
    logic [1:0]  req_op;
    logic [15:0] req_size;
    logic        resp_valid;
    logic        resp_err;

    int vectors     = 0;
    int miscompares = 0;

    cfg_txn_launcher #(.TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_size       (cfg_size),
        .cfg_type       (cfg_type),
        .cfg_read_data  (cfg_read_data),
        .cfg_read_valid (cfg_read_valid),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_op         (req_op),
        .req_size       (req_size),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [11:0] a, input logic [63:0] d);
        cfg_valid = 1'b1;
        cfg_type  = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [11:0] a, input logic [63:0] exp);
        cfg_valid = 1'b1;
        cfg_type  = 1'b0;
        cfg_addr  = a;
        cycle();
        cfg_valid = 1'b0;
        check({tag, "_rvalid"}, 64'(cfg_read_valid), 64'd1);
        check(tag, cfg_read_data, exp);
    endtask

    task automatic respond(input logic e);
        resp_valid = 1'b1;
        resp_err   = e;
        cycle();
        resp_valid = 1'b0;
        resp_err   = 1'b0;
    endtask

    task automatic handshake();
        req_ready = 1'b1;
        cycle();
        req_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        cfg_size   = 3'd3;
        cfg_type   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_req_addr", 64'(req_addr), 64'd0);
        check("rst_rvalid", 64'(cfg_read_valid), 64'd0);
        check("rst_rdata", cfg_read_data, 64'd0);

        // Basic launch with back-pressure on the request.
        cfg_write(12'h00, 64'h1234_5678);
        cfg_write(12'h04, 64'd1);
        cfg_write(12'h08, 64'd64);
        cfg_write(12'h0C, 64'd1);
        check("t1_req_valid", 64'(req_valid), 64'd1);
        check("t1_req_addr", 64'(req_addr), 64'h1234_5678);
        check("t1_req_op", 64'(req_op), 64'd1);
        check("t1_req_size", 64'(req_size), 64'd64);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t1_req_hold", 64'(req_valid), 64'd1);
        end
        handshake();
        check("t1_req_drop", 64'(req_valid), 64'd0);
        check_reg("t1_busy_wait", 12'h0C, 64'd1);
        respond(1'b0);
        check_reg("t1_status", 12'h10, 64'h1);
        check_reg("t1_done_cnt", 12'h14, 64'd1);
        check_reg("t1_busy_idle", 12'h0C, 64'd0);

        // Read timing and unmapped read.
        cfg_write(12'h00, 64'hABC);
        check("t2_wr_no_strobe", 64'(cfg_read_valid), 64'd0);
        check_reg("t2_txn_addr", 12'h00, 64'hABC);
        cycle();
        check("t2_rvalid_drop", 64'(cfg_read_valid), 64'd0);
        check_reg("t2_unmapped", 12'h20, 64'd0);

        // Start while busy is rejected; in-flight request untouched.
        cfg_write(12'h00, 64'h5000);
        cfg_write(12'h0C, 64'd1);
        handshake();
        check_reg("t3_status_cleared", 12'h10, 64'h0);
        cfg_write(12'h0C, 64'd1);
        cfg_write(12'h00, 64'h999);
        check("t3_req_addr_stable", 64'(req_addr), 64'h5000);
        check_reg("t3_status_reject", 12'h10, 64'h2);
        check_reg("t3_txn_addr_new", 12'h00, 64'h999);
        respond(1'b0);
        check_reg("t3_status_done", 12'h10, 64'h1);
        check_reg("t3_done_cnt", 12'h14, 64'd2);
        check_reg("t3_done_cnt_once", 12'h14, 64'd2);

        // Synchronous reset clears everything.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reg("rst2_txn_addr", 12'h00, 64'd0);
        check_reg("rst2_txn_op", 12'h04, 64'd0);
        check_reg("rst2_txn_size", 12'h08, 64'd0);
        check_reg("rst2_status", 12'h10, 64'd0);
        check_reg("rst2_done_cnt", 12'h14, 64'd0);

        // Zero-size start completes immediately with error, no request.
        cfg_write(12'h0C, 64'd1);
        check("t4_no_req0", 64'(req_valid), 64'd0);
        cycle();
        check("t4_no_req1", 64'(req_valid), 64'd0);
        check_reg("t4_status", 12'h10, 64'h3);
        check_reg("t4_done_cnt", 12'h14, 64'd1);
        check_reg("t4_busy", 12'h0C, 64'd0);
        cfg_write(12'h10, 64'h7);
        check_reg("t4_status_w1c", 12'h10, 64'h0);

        // Engine error response.
        cfg_write(12'h08, 64'd8);
        cfg_write(12'h0C, 64'd1);
        handshake();
        respond(1'b1);
        check_reg("t5_status_err", 12'h10, 64'h3);
        check_reg("t5_done_cnt", 12'h14, 64'd2);

        // W1C and hardware set in the same cycle: set wins.
        cfg_write(12'h0C, 64'd1);
        check_reg("t6_status_cleared", 12'h10, 64'h0);
        handshake();
        cfg_valid  = 1'b1;
        cfg_type   = 1'b1;
        cfg_addr   = 12'h10;
        cfg_data   = 64'h7;
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        cycle();
        cfg_valid  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        check_reg("t6_set_wins", 12'h10, 64'h3);
        check_reg("t6_done_cnt", 12'h14, 64'd3);

        // Reset during ISSUE; later stray response ignored.
        cfg_write(12'h00, 64'hABCD);
        cfg_write(12'h0C, 64'd1);
        check("t7_req_valid", 64'(req_valid), 64'd1);
        check("t7_req_addr", 64'(req_addr), 64'hABCD);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t7_req_valid_rst", 64'(req_valid), 64'd0);
        check("t7_req_addr_rst", 64'(req_addr), 64'd0);
        respond(1'b1);
        check_reg("t7_status", 12'h10, 64'd0);
        check_reg("t7_done_cnt", 12'h14, 64'd0);
        check_reg("t7_busy", 12'h0C, 64'd0);
        check_reg("t7_txn_addr", 12'h00, 64'd0);

        // Unanswered request: bounded only when the timeout is built in.
        cfg_write(12'h08, 64'd8);
        cfg_write(12'h0C, 64'd1);
        handshake();
`ifdef CFG_TXN_TIMEOUT_EN
        repeat (14) cycle();
        check_reg("t8_busy_before", 12'h0C, 64'd1);
        check_reg("t8_status_before", 12'h10, 64'h0);
        check_reg("t8_busy_after", 12'h0C, 64'd0);
        check_reg("t8_status_timeout", 12'h10, 64'h7);
        check_reg("t8_done_cnt", 12'h14, 64'd1);
`else
        repeat (100) cycle();
        check_reg("t8_busy_unbounded", 12'h0C, 64'd1);
        check_reg("t8_status_pending", 12'h10, 64'h0);
        respond(1'b0);
        check_reg("t8_status_done", 12'h10, 64'h1);
        check_reg("t8_done_cnt", 12'h14, 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cfg_txn_launcher.md
Name: cfg_txn_launcher

Overview:
- Slave endpoint of the tile's uncached config bus (valid/addr/data/size/config_type in; read_data/read_valid out).
- Decodes config writes into a small register file: transaction address, op, size, start.
- On start, launches one request to the downstream transaction engine over a valid/ready handshake, waits for its response, and exposes busy/done/err status and a completion counter for software polling.

Parameters:
- CFG_ADDR_W, 12, config register offset width
- DATA_W, 64, config data width
- PADDR_W, 40, physical address width of launched transaction
- OP_W, 2, op field width (0 load, 1 store, 2/3 reserved-legal)
- SIZE_W, 16, transaction size in bytes
- TIMEOUT_CYCLES, 1024, response timeout (used only with optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config access strobe, one cycle per access
- cfg_addr  in  CFG_ADDR_W  register offset
- cfg_data  in  DATA_W  write data
- cfg_size  in  3  access size; ignored, all accesses full-register
- cfg_type  in  1  1 = write, 0 = read
- cfg_read_data  out  DATA_W  read return data
- cfg_read_valid  out  1  read return strobe
- req_valid  out  1  transaction request valid
- req_ready  in  1  engine accepts request
- req_addr  out  PADDR_W  request address
- req_op  out  OP_W  request op
- req_size  out  SIZE_W  request byte count
- resp_valid  in  1  engine completion strobe
- resp_err  in  1  engine reports error with completion

Behaviour:
- Register map (8-byte-spaced offsets are not used; offsets as listed):
  - 0x00 TXN_ADDR: rw, low PADDR_W bits.
  - 0x04 TXN_OP: rw, low OP_W bits.
  - 0x08 TXN_SIZE: rw, low SIZE_W bits.
  - 0x0C CTRL: write with bit0 = 1 issues start; read returns {63'b0, busy}.
  - 0x10 STATUS: read returns {61'b0, err_timeout, err, done}; write-1-to-clear on bits 0..2.
  - 0x14 DONE_CNT: ro, 32-bit count of completed transactions, wraps 0xFFFFFFFF -> 0.
  - Unmapped offsets: writes dropped; reads return 0 with cfg_read_valid.
- Reads: cfg_read_valid and cfg_read_data are registered, exactly 1 cycle after a cfg_valid read. Writes produce no strobe. Read data reflects register state before any same-cycle update.
- Arg registers (0x00/0x04/0x08) are writable at any time. On accepted start they are snapshotted into req_addr/req_op/req_size, which stay stable until the handshake completes.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE + start write, size != 0: go to ISSUE, clear done/err/err_timeout.
  - IDLE + start write, size == 0: no request issued; next cycle set done = 1, err = 1, DONE_CNT += 1; stay in IDLE.
  - ISSUE: req_valid = 1. Stay until req_ready; on req_valid & req_ready go to WAIT.
  - WAIT: on resp_valid set done = 1, err = resp_err, DONE_CNT += 1, go to IDLE.
  - resp_valid outside WAIT is ignored.
- busy = (state != IDLE). A start while busy is rejected, sets err = 1, and leaves the in-flight transaction untouched.
- A start in the same cycle as the completing resp_valid is rejected, because busy is sampled from the current state.
- Same-cycle STATUS W1C and hardware set of the same bit: set wins.
- Reset values: all registers 0, state IDLE, req_valid 0, req_* 0, cfg_read_valid 0, cfg_read_data 0.
- Reset mid-transaction returns to IDLE immediately and drops req_valid the next edge; a later resp_valid is ignored.

Optional Feature:
- Macro: CFG_TXN_TIMEOUT_EN.
- Enabled:
  - A counter starts at 0 on entry to WAIT and increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 without resp_valid: go to IDLE, set done = 1, err = 1, err_timeout = 1, DONE_CNT += 1.
  - resp_valid on the expiry cycle takes priority as a normal completion.
- Disabled: WAIT has no bound; STATUS bit2 always reads 0 and its counter logic is absent.

Test Plan:
- Write 0x00 = 0x12345678, 0x04 = 1, 0x08 = 64, 0x0C = 1 -> next cycle req_valid = 1 with req_addr 0x12345678, op 1, size 64; hold req_ready low 5 cycles then high -> req_valid drops next cycle; resp_valid -> STATUS reads 0x1, DONE_CNT reads 1.
- Read 0x00 after writing 0xABC -> cfg_read_valid exactly 1 cycle later with data 0xABC; read 0x20 -> cfg_read_valid with data 0.
- Start while in WAIT, plus rewrite 0x00 = 0x999 -> req_addr unchanged, STATUS err = 1; completion then -> done = 1, DONE_CNT increments once.
- Start with TXN_SIZE = 0 -> no req_valid ever; STATUS reads 0x3, DONE_CNT = 1. Write STATUS 0x7 -> reads 0x0.
- resp_valid with resp_err = 1 -> STATUS 0x3. Assert rst during ISSUE -> req_valid 0, all regs 0, a stray resp_valid changes nothing.
- CFG_TXN_TIMEOUT_EN with TIMEOUT_CYCLES = 16, no resp -> STATUS reads 0x7 after 16 cycles in WAIT, busy = 0. Without the macro, same stimulus -> busy stays 1 at 100 cycles.
